// File: rtl/mem_arbiter.sv
// Shares one burst-memory port between the dcache (dfp0) and icache (dfp1) line-miss ports.
// Round-robin grant, one transaction in flight, 256-bit lines moved as 64-bit beats.

module mem_arbiter_chk (
    input  logic clk,
    input  logic rst,
    input  logic busy_s,
    input  logic granted_pending_s
);
    // A granted requester must keep its request up until it sees its resp pulse.
    property p_req_held;
        @(posedge clk) disable iff (rst) busy_s |-> granted_pending_s;
    endproperty
    a_req_held: assert property (p_req_held)
        else $error("mem_arbiter: granted requester dropped its request before resp");
endmodule

module mem_arbiter #(
    parameter  int BEAT_W = 64,
    parameter  int BEATS  = 4,
    localparam int LINE_W = BEAT_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dfp0_addr,
    input  logic              dfp0_read,
    input  logic              dfp0_write,
    input  logic [LINE_W-1:0] dfp0_wdata,
    output logic [LINE_W-1:0] dfp0_rdata,
    output logic              dfp0_resp,
    input  logic [31:0]       dfp1_addr,
    input  logic              dfp1_read,
    input  logic              dfp1_write,
    input  logic [LINE_W-1:0] dfp1_wdata,
    output logic [LINE_W-1:0] dfp1_rdata,
    output logic              dfp1_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_COLLECT = 3'd2,
        WR_BURST   = 3'd3,
        RESP       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       bmem_addr_q, bmem_addr_d;
    logic              bmem_read_q, bmem_read_d;
    logic              bmem_write_q, bmem_write_d;
    logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;
    logic [LINE_W-1:0] dfp0_rdata_q, dfp0_rdata_d;
    logic [LINE_W-1:0] dfp1_rdata_q, dfp1_rdata_d;
    logic              dfp0_resp_q, dfp0_resp_d;
    logic              dfp1_resp_q, dfp1_resp_d;

    logic pend0_s, pend1_s, pick1_s, pick_write_s;
    logic busy_s, granted_pending_s;

    function automatic logic [BEAT_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                    input logic [CNT_W-1:0]  idx);
        line_beat = line[int'(idx)*BEAT_W +: BEAT_W];
    endfunction

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        pend0_s = dfp0_read | dfp0_write;
        pend1_s = dfp1_read | dfp1_write;
        if (pend0_s && pend1_s) begin
            pick1_s = ~last_grant_q;
        end else begin
            pick1_s = pend1_s;
        end
        pick_write_s = pick1_s ? dfp1_write : dfp0_write;
    end

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        line_d       = line_q;
        bmem_addr_d  = bmem_addr_q;
        bmem_read_d  = bmem_read_q;
        bmem_write_d = bmem_write_q;
        bmem_wdata_d = bmem_wdata_q;
        dfp0_rdata_d = '0;
        dfp1_rdata_d = '0;
        dfp0_resp_d  = 1'b0;
        dfp1_resp_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend0_s || pend1_s) begin
                    grant_d      = pick1_s;
                    last_grant_d = pick1_s;
                    cnt_d        = '0;
                    bmem_addr_d  = (pick1_s ? dfp1_addr : dfp0_addr) & ~32'h0000_001F;
                    if (pick_write_s) begin
                        line_d       = pick1_s ? dfp1_wdata : dfp0_wdata;
                        bmem_write_d = 1'b1;
                        bmem_wdata_d = line_beat(line_d, '0);
                        state_d      = WR_BURST;
                    end else begin
                        line_d      = '0;
                        bmem_read_d = 1'b1;
                        state_d     = RD_ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                if (bmem_ready) begin
                    bmem_read_d = 1'b0;
                    state_d     = RD_COLLECT;
                end else begin
                    state_d = RD_ISSUE;
                end
            end
            RD_COLLECT: begin
                // Only beats tagged with our own address belong to this line.
                if (bmem_rvalid && (bmem_raddr == bmem_addr_q)) begin
                    line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bmem_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                        if (grant_q) begin
                            dfp1_resp_d  = 1'b1;
                            dfp1_rdata_d = line_d;
                        end else begin
                            dfp0_resp_d  = 1'b1;
                            dfp0_rdata_d = line_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = RD_COLLECT;
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        bmem_write_d = 1'b0;
                        bmem_wdata_d = '0;
                        state_d      = RESP;
                        if (grant_q) begin
                            dfp1_resp_d = 1'b1;
                        end else begin
                            dfp0_resp_d = 1'b1;
                        end
                    end else begin
                        cnt_d        = cnt_q + 1'b1;
                        bmem_wdata_d = line_beat(line_q, cnt_q + 1'b1);
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            line_q       <= '0;
            bmem_addr_q  <= 32'h0000_0000;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
            dfp0_rdata_q <= '0;
            dfp1_rdata_q <= '0;
            dfp0_resp_q  <= 1'b0;
            dfp1_resp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            line_q       <= line_d;
            bmem_addr_q  <= bmem_addr_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            bmem_wdata_q <= bmem_wdata_d;
            dfp0_rdata_q <= dfp0_rdata_d;
            dfp1_rdata_q <= dfp1_rdata_d;
            dfp0_resp_q  <= dfp0_resp_d;
            dfp1_resp_q  <= dfp1_resp_d;
        end
    end

    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;
    assign dfp0_rdata = dfp0_rdata_q;
    assign dfp1_rdata = dfp1_rdata_q;
    assign dfp0_resp  = dfp0_resp_q;
    assign dfp1_resp  = dfp1_resp_q;

    assign busy_s            = (state_q == RD_ISSUE) || (state_q == RD_COLLECT) || (state_q == WR_BURST);
    assign granted_pending_s = grant_q ? pend1_s : pend0_s;

    mem_arbiter_chk u_chk (
        .clk               (clk),
        .rst               (rst),
        .busy_s            (busy_s),
        .granted_pending_s (granted_pending_s)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bmem responder model, per-port response scoreboards,
// a table of single transactions and hand-written arbitration/stall/stray-beat/reset sequences.

module tb_mem_arbiter;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = BEAT_W * BEATS;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       dfp0_addr, dfp1_addr;
    logic              dfp0_read, dfp0_write, dfp1_read, dfp1_write;
    logic [LINE_W-1:0] dfp0_wdata, dfp1_wdata, dfp0_rdata, dfp1_rdata;
    logic              dfp0_resp, dfp1_resp;
    logic [31:0]       bmem_addr, bmem_raddr;
    logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;

    mem_arbiter #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .dfp0_addr(dfp0_addr), .dfp0_read(dfp0_read), .dfp0_write(dfp0_write),
        .dfp0_wdata(dfp0_wdata), .dfp0_rdata(dfp0_rdata), .dfp0_resp(dfp0_resp),
        .dfp1_addr(dfp1_addr), .dfp1_read(dfp1_read), .dfp1_write(dfp1_write),
        .dfp1_wdata(dfp1_wdata), .dfp1_rdata(dfp1_rdata), .dfp1_resp(dfp1_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [LINE_W-1:0] rdata; bit wr; } sb_t;
    typedef struct {
        bit                port;
        bit                wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] line;
        logic [31:0]       exp_baddr;
        int                exp_lat;
    } vec_t;

    sb_t  q0[$], q1[$];
    vec_t vecs[5];

    int total = 0, bad = 0, cyc = 0;
    int resp_count = 0, last_resp_port = -1, last_resp_cyc = 0;
    int first_rd_cyc = -1, first_wr_cyc = -1;
    logic [31:0] rd_req_addr;
    // bmem responder model state
    bit          rd_active = 1'b0;
    logic [31:0] rd_addr;
    int          rd_k = 0, phase = 0;
    bit          bad_mode = 1'b0;
    int          stall_on_beat = -1, ready_low = 0;
    logic [LINE_W-1:0] wr_line;
    logic [31:0]       wr_addr;
    int                wr_k = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BEAT_W-1:0] beat_val(input logic [31:0] a, input int k);
        beat_val = {a, 32'hB0B0_0000 + 32'(k)};
    endfunction

    function automatic logic [LINE_W-1:0] exp_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = beat_val(a, k);
        return l;
    endfunction

    task automatic got_resp(input int p, input logic [LINE_W-1:0] data);
        sb_t e;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL spurious_resp: port %0d resp=1 expected 0 (cycle %0d)", p, cyc);
        end else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check("resp_rdata", data, e.rdata);
            if (e.wr) begin
                check("wr_beat_count", wr_k, BEATS);
                wr_k = 0;
            end
            if (p == 0) begin dfp0_read = 1'b0; dfp0_write = 1'b0; end
            else        begin dfp1_read = 1'b0; end
        end
        last_resp_port = p;
        last_resp_cyc  = cyc;
        resp_count++;
    endtask

    task automatic drive_bmem();
        if (ready_low > 0) begin
            bmem_ready = 1'b0;
            ready_low--;
        end else if (stall_on_beat >= 0 && bmem_write && wr_k == stall_on_beat) begin
            bmem_ready    = 1'b0;
            ready_low     = 2;
            stall_on_beat = -1;
        end else begin
            bmem_ready = 1'b1;
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = 32'h0;
        bmem_rdata  = 64'h0;
        if (rd_active) begin
            if (bad_mode && phase == 1) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = rd_addr ^ 32'h0000_0100;
                bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (bad_mode && phase == 2) begin
                bmem_raddr = rd_addr;
                bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            end else begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = rd_addr;
                bmem_rdata  = beat_val(rd_addr, rd_k);
                rd_k++;
                if (rd_k == BEATS) rd_active = 1'b0;
            end
            phase = (phase + 1) % 3;
        end
    endtask

    // One clock: check/record handshakes completing at the edge, then observe and re-drive.
    task automatic step();
        bit wr_acc, rd_acc;
        wr_acc = bmem_write && bmem_ready;
        rd_acc = bmem_read && bmem_ready;
        if (bmem_write) begin
            if (wr_k < BEATS) check("wr_beat", bmem_wdata, wr_line[wr_k*BEAT_W +: BEAT_W]);
            else check("wr_extra_beat", wr_k, BEATS - 1);
            check("wr_addr", bmem_addr, wr_addr);
        end
        if (wr_acc) wr_k++;
        if (rd_acc) begin
            rd_active = 1'b1;
            rd_addr   = bmem_addr;
            rd_k      = 0;
            phase     = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (dfp0_resp) got_resp(0, dfp0_rdata);
        if (dfp1_resp) got_resp(1, dfp1_rdata);
        if (bmem_read && first_rd_cyc < 0) begin
            first_rd_cyc = cyc;
            rd_req_addr  = bmem_addr;
        end
        if (bmem_write && first_wr_cyc < 0) first_wr_cyc = cyc;
        drive_bmem();
    endtask

    task automatic issue(input bit port, input bit wr, input logic [31:0] addr,
                         input logic [LINE_W-1:0] line, input logic [31:0] baddr);
        sb_t e;
        e.wr    = wr;
        e.rdata = wr ? '0 : exp_line(baddr);
        if (wr) begin
            wr_line = line;
            wr_addr = baddr;
            wr_k    = 0;
        end
        if (port) begin
            dfp1_addr = addr; dfp1_read = 1'b1;
            q1.push_back(e);
        end else begin
            dfp0_addr = addr; dfp0_wdata = line;
            if (wr) dfp0_write = 1'b1;
            else    dfp0_read  = 1'b1;
            q0.push_back(e);
        end
        first_rd_cyc = -1;
        first_wr_cyc = -1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((q0.size() + q1.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_timeout"}, n < budget, 1'b1);
    endtask

    task automatic wait_resp(input string name, input int exp_port);
        int n = 0;
        int c0 = resp_count;
        while (resp_count == c0 && n < 60) begin
            step();
            n++;
        end
        check({name, "_timeout"}, n < 60, 1'b1);
        check(name, last_resp_port, exp_port);
    endtask

    initial begin
        int t0, n;
        rst = 1'b1;
        dfp0_addr = 32'h0; dfp1_addr = 32'h0;
        dfp0_read = 1'b0; dfp0_write = 1'b0; dfp1_read = 1'b0; dfp1_write = 1'b0;
        dfp0_wdata = '0; dfp1_wdata = '0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = 32'h0; bmem_rdata = 64'h0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1024, '0, 32'h0000_1020, 6};
        vecs[1] = '{1'b0, 1'b1, 32'h8000_0040,
                    {64'h4444_4444_DDDD_0003, 64'h3333_3333_CCCC_0002,
                     64'h2222_2222_BBBB_0001, 64'h1111_1111_AAAA_0000}, 32'h8000_0040, 5};
        vecs[2] = '{1'b0, 1'b0, 32'hDEAD_BEEF, '0, 32'hDEAD_BEE0, 6};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_003F,
                    {64'hFFFF_0000_FFFF_0003, 64'h0123_4567_89AB_CDEF,
                     64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001}, 32'h0000_0020, 5};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, '0, 32'hFFFF_FFE0, 6};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {bmem_read, bmem_write, dfp0_resp, dfp1_resp}, 4'b0000);
        check("rst_addr", bmem_addr, 32'h0);
        check("rst_wdata", bmem_wdata, 64'h0);
        check("rst_rdata0", dfp0_rdata, '0);
        check("rst_rdata1", dfp1_rdata, '0);
        rst = 1'b0;
        drive_bmem();
        step();

        // Simultaneous reads straight after reset: dcache first, then alternate.
        issue(1'b0, 1'b0, 32'h0000_4000, '0, 32'h0000_4000);
        issue(1'b1, 1'b0, 32'h0000_5000, '0, 32'h0000_5000);
        wait_resp("rr_first", 0);
        issue(1'b0, 1'b0, 32'h0000_6000, '0, 32'h0000_6000);
        wait_resp("rr_second", 1);
        wait_resp("rr_third", 0);
        step();

        for (int i = 0; i < 5; i++) begin
            t0 = cyc;
            issue(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].line, vecs[i].exp_baddr);
            run_until_idle("vec", 40);
            check("vec_latency", last_resp_cyc - t0, vecs[i].exp_lat);
            if (vecs[i].wr) begin
                check("vec_first_wbeat", first_wr_cyc - t0, 1);
            end else begin
                check("vec_first_rreq", first_rd_cyc - t0, 1);
                check("vec_rreq_addr", rd_req_addr, vecs[i].exp_baddr);
            end
            step();
        end

        // Ready held low for 3 cycles while write beat 2 is presented.
        stall_on_beat = 2;
        t0 = cyc;
        issue(1'b0, 1'b1, 32'h0000_7000, vecs[1].line ^ {4{64'h5A5A_5A5A_5A5A_5A5A}}, 32'h0000_7000);
        run_until_idle("stall", 40);
        check("stall_latency", last_resp_cyc - t0, 8);
        step();

        // Foreign-address and invalid beats interleaved with the real ones.
        bad_mode = 1'b1;
        issue(1'b1, 1'b0, 32'h2000_0010, '0, 32'h2000_0000);
        run_until_idle("stray", 60);
        bad_mode = 1'b0;
        step();

        // Reset after two beats of a read; leftover beats must be ignored.
        issue(1'b1, 1'b0, 32'h0000_3000, '0, 32'h0000_3000);
        n = 0;
        while (rd_k < 3 && n < 40) begin
            step();
            n++;
        end
        check("midrst_timeout", n < 40, 1'b1);
        #2;
        rst = 1'b1;
        dfp1_read = 1'b0;
        q1.delete();
        #1;
        check("midrst_ctl", {bmem_read, bmem_write, dfp0_resp, dfp1_resp}, 4'b0000);
        check("midrst_addr", bmem_addr, 32'h0);
        check("midrst_rdata1", dfp1_rdata, '0);
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_idle", {bmem_read, bmem_write}, 2'b00);
        issue(1'b1, 1'b0, 32'h0000_3000, '0, 32'h0000_3000);
        run_until_idle("after_rst", 40);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
